// File: rtl/reservation_station_if.sv
// Dispatch, writeback-broadcast and issue signals shared between the scheduler front end
// and the reservation station.
interface reservation_station_if #(
    parameter int REG_SIZE = 32,
    parameter int NUM_TAGS = 64,
    parameter int ROB_SIZE = 64,
    parameter int RS_SIZE  = 16
);
    localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS);
    localparam int ROB_SIZE_LOG2 = $clog2(ROB_SIZE);
    localparam int RS_SIZE_LOG2  = $clog2(RS_SIZE + 1);

    logic                     disp_valid;
    logic [3:0]               disp_op;
    logic [NUM_TAGS_LOG2-1:0] disp_src1_tag;
    logic [NUM_TAGS_LOG2-1:0] disp_src2_tag;
    logic                     disp_src1_rdy;
    logic                     disp_src2_rdy;
    logic [REG_SIZE-1:0]      disp_src1_val;
    logic [REG_SIZE-1:0]      disp_src2_val;
    logic [NUM_TAGS_LOG2-1:0] disp_rd_tag;
    logic [ROB_SIZE_LOG2-1:0] disp_rob_index;
    logic                     disp_loadstore;

    logic                     wb_valid;
    logic [NUM_TAGS_LOG2-1:0] wb_tag;
    logic [REG_SIZE-1:0]      wb_value;

    logic                     flush;
    logic                     full;
    logic [RS_SIZE_LOG2-1:0]  count;

    logic [3:0]               op;
    logic [REG_SIZE-1:0]      rs1;
    logic [REG_SIZE-1:0]      rs2;
    logic [NUM_TAGS_LOG2-1:0] tags_out;
    logic [ROB_SIZE_LOG2-1:0] rob_index_out;
    logic                     valid_out;
    logic                     loadstore_out;

    modport master (
        output disp_valid, disp_op, disp_src1_tag, disp_src2_tag, disp_src1_rdy,
               disp_src2_rdy, disp_src1_val, disp_src2_val, disp_rd_tag,
               disp_rob_index, disp_loadstore, wb_valid, wb_tag, wb_value, flush,
        input  full, count, op, rs1, rs2, tags_out, rob_index_out, valid_out,
               loadstore_out
    );

    modport slave (
        input  disp_valid, disp_op, disp_src1_tag, disp_src2_tag, disp_src1_rdy,
               disp_src2_rdy, disp_src1_val, disp_src2_val, disp_rd_tag,
               disp_rob_index, disp_loadstore, wb_valid, wb_tag, wb_value, flush,
        output full, count, op, rs1, rs2, tags_out, rob_index_out, valid_out,
               loadstore_out
    );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops until both operands are ready (via dispatch,
// bypass or writeback wakeup) and issues the lowest-index ready entry each cycle.
module reservation_station #(
    parameter int REG_SIZE = 32,
    parameter int NUM_TAGS = 64,
    parameter int ROB_SIZE = 64,
    parameter int RS_SIZE  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    reservation_station_if.slave  bus
);
    localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS);
    localparam int ROB_SIZE_LOG2 = $clog2(ROB_SIZE);
    localparam int RS_SIZE_LOG2  = $clog2(RS_SIZE + 1);
    localparam int IDX_W         = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic                     busy;
        logic [3:0]               op;
        logic [NUM_TAGS_LOG2-1:0] src1_tag;
        logic                     src1_rdy;
        logic [REG_SIZE-1:0]      src1_val;
        logic [NUM_TAGS_LOG2-1:0] src2_tag;
        logic                     src2_rdy;
        logic [REG_SIZE-1:0]      src2_val;
        logic [NUM_TAGS_LOG2-1:0] rd_tag;
        logic [ROB_SIZE_LOG2-1:0] rob_index;
        logic                     loadstore;
    } entry_t;

    entry_t                   entry_q [RS_SIZE];
    entry_t                   entry_d [RS_SIZE];
    entry_t                   disp_entry;

    logic [RS_SIZE_LOG2-1:0]  count_q, count_d;
    logic [3:0]               op_q, op_d;
    logic [REG_SIZE-1:0]      rs1_q, rs1_d;
    logic [REG_SIZE-1:0]      rs2_q, rs2_d;
    logic [NUM_TAGS_LOG2-1:0] tags_out_q, tags_out_d;
    logic [ROB_SIZE_LOG2-1:0] rob_index_out_q, rob_index_out_d;
    logic                     valid_out_q, valid_out_d;
    logic                     loadstore_out_q, loadstore_out_d;

    logic [RS_SIZE-1:0]       busy_vec;
    logic [RS_SIZE-1:0]       ready_vec;
    logic                     full;
    logic                     free_found, sel_found;
    logic [IDX_W-1:0]         free_idx, sel_idx;
    logic                     disp_accept, issue;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entry_q[i].busy;
            ready_vec[i] = entry_q[i].busy & entry_q[i].src1_rdy & entry_q[i].src2_rdy;
        end
    end

    // Descending scans so the last hit, and therefore the winner, is the lowest index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_found = 1'b1;
                free_idx   = i[IDX_W-1:0];
            end
            if (ready_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = i[IDX_W-1:0];
            end
        end
    end

    assign full        = &busy_vec;
    assign disp_accept = bus.disp_valid & free_found & ~bus.flush;
    assign issue       = sel_found & ~bus.flush;

    // Incoming operands may be satisfied by the result broadcast in the same cycle.
    always_comb begin
        disp_entry           = '0;
        disp_entry.busy      = 1'b1;
        disp_entry.op        = bus.disp_op;
        disp_entry.src1_tag  = bus.disp_src1_tag;
        disp_entry.src1_rdy  = bus.disp_src1_rdy;
        disp_entry.src1_val  = bus.disp_src1_val;
        disp_entry.src2_tag  = bus.disp_src2_tag;
        disp_entry.src2_rdy  = bus.disp_src2_rdy;
        disp_entry.src2_val  = bus.disp_src2_val;
        disp_entry.rd_tag    = bus.disp_rd_tag;
        disp_entry.rob_index = bus.disp_rob_index;
        disp_entry.loadstore = bus.disp_loadstore;
        if (bus.wb_valid && !bus.disp_src1_rdy && bus.disp_src1_tag == bus.wb_tag) begin
            disp_entry.src1_rdy = 1'b1;
            disp_entry.src1_val = bus.wb_value;
        end
        if (bus.wb_valid && !bus.disp_src2_rdy && bus.disp_src2_tag == bus.wb_tag) begin
            disp_entry.src2_rdy = 1'b1;
            disp_entry.src2_val = bus.wb_value;
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].busy && bus.wb_valid) begin
                if (!entry_q[i].src1_rdy && entry_q[i].src1_tag == bus.wb_tag) begin
                    entry_d[i].src1_rdy = 1'b1;
                    entry_d[i].src1_val = bus.wb_value;
                end
                if (!entry_q[i].src2_rdy && entry_q[i].src2_tag == bus.wb_tag) begin
                    entry_d[i].src2_rdy = 1'b1;
                    entry_d[i].src2_val = bus.wb_value;
                end
            end
        end
        if (issue) begin
            entry_d[sel_idx].busy = 1'b0;
        end
        if (disp_accept) begin
            entry_d[free_idx] = disp_entry;
        end
        if (bus.flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_d[i].busy     = 1'b0;
                entry_d[i].src1_rdy = 1'b0;
                entry_d[i].src2_rdy = 1'b0;
            end
        end
    end

    // Idle and flushed cycles present an all-zero payload rather than holding the last issue.
    always_comb begin
        op_d            = '0;
        rs1_d           = '0;
        rs2_d           = '0;
        tags_out_d      = '0;
        rob_index_out_d = '0;
        valid_out_d     = 1'b0;
        loadstore_out_d = 1'b0;
        if (issue) begin
            op_d            = entry_q[sel_idx].op;
            rs1_d           = entry_q[sel_idx].src1_val;
            rs2_d           = entry_q[sel_idx].src2_val;
            tags_out_d      = entry_q[sel_idx].rd_tag;
            rob_index_out_d = entry_q[sel_idx].rob_index;
            valid_out_d     = 1'b1;
            loadstore_out_d = entry_q[sel_idx].loadstore;
        end
        if (bus.flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + RS_SIZE_LOG2'(disp_accept) - RS_SIZE_LOG2'(issue);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            count_q         <= '0;
            op_q            <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            tags_out_q      <= '0;
            rob_index_out_q <= '0;
            valid_out_q     <= 1'b0;
            loadstore_out_q <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= entry_d[i];
            end
            count_q         <= count_d;
            op_q            <= op_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            tags_out_q      <= tags_out_d;
            rob_index_out_q <= rob_index_out_d;
            valid_out_q     <= valid_out_d;
            loadstore_out_q <= loadstore_out_d;
        end
    end

    assign bus.full          = full;
    assign bus.count         = count_q;
    assign bus.op            = op_q;
    assign bus.rs1           = rs1_q;
    assign bus.rs2           = rs2_q;
    assign bus.tags_out      = tags_out_q;
    assign bus.rob_index_out = rob_index_out_q;
    assign bus.valid_out     = valid_out_q;
    assign bus.loadstore_out = loadstore_out_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: stimulus pushes expected issues into a scoreboard
// queue that a negedge monitor pops whenever valid_out is seen.
module tb_reservation_station;
    logic clk = 1'b0;
    logic rst = 1'b0;

    reservation_station_if bus ();

    reservation_station dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  tag;
        logic [5:0]  rob;
        logic        ls;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   failed    = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int op, input int t1, input int r1, input int v1,
                                 input int t2, input int r2, input int v2,
                                 input int rd, input int rob, input int ls);
        bus.disp_op        = 4'(op);
        bus.disp_src1_tag  = 6'(t1);
        bus.disp_src1_rdy  = 1'(r1);
        bus.disp_src1_val  = 32'(v1);
        bus.disp_src2_tag  = 6'(t2);
        bus.disp_src2_rdy  = 1'(r2);
        bus.disp_src2_val  = 32'(v2);
        bus.disp_rd_tag    = 6'(rd);
        bus.disp_rob_index = 6'(rob);
        bus.disp_loadstore = 1'(ls);
        bus.disp_valid     = 1'b1;
        cycle();
        bus.disp_valid     = 1'b0;
    endtask

    task automatic wakeup(input int tag, input int value);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 6'(tag);
        bus.wb_value = 32'(value);
        cycle();
        bus.wb_valid = 1'b0;
    endtask

    // Monitor: every issue seen out of reset must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    failed++;
                    $display("[TB] FAIL unexpected_issue: got valid_out=1 op=0x%0h rs1=0x%0h, expected valid_out=0",
                             bus.op, bus.rs1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("issue_op",  32'(bus.op),            32'(e.op));
                    checkOutput("issue_rs1", bus.rs1,                e.rs1);
                    checkOutput("issue_rs2", bus.rs2,                e.rs2);
                    checkOutput("issue_tag", 32'(bus.tags_out),      32'(e.tag));
                    checkOutput("issue_rob", 32'(bus.rob_index_out), 32'(e.rob));
                    checkOutput("issue_ls",  32'(bus.loadstore_out), 32'(e.ls));
                end
            end
        end
    end

    initial begin
        bus.disp_valid = 1'b0;
        bus.disp_op = '0; bus.disp_src1_tag = '0; bus.disp_src2_tag = '0;
        bus.disp_src1_rdy = 1'b0; bus.disp_src2_rdy = 1'b0;
        bus.disp_src1_val = '0; bus.disp_src2_val = '0;
        bus.disp_rd_tag = '0; bus.disp_rob_index = '0; bus.disp_loadstore = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_tag = '0; bus.wb_value = '0;
        bus.flush = 1'b0;

        #12;
        checkOutput("reset_count", 32'(bus.count),     0);
        checkOutput("reset_full",  32'(bus.full),      0);
        checkOutput("reset_valid", 32'(bus.valid_out), 0);
        checkOutput("reset_rs1",   bus.rs1,            0);
        cycle();
        rst = 1'b1;
        cycle();

        // Both operands ready at dispatch: issue on the next edge, then idle.
        exp_q.push_back('{4'h0, 32'd5, 32'd7, 6'd3, 6'd9, 1'b0});
        applyStimulus(0, 0, 1, 5, 0, 1, 7, 3, 9, 0);
        checkOutput("t1_count_after_dispatch", 32'(bus.count), 1);
        cycle();
        checkOutput("t1_count_after_issue", 32'(bus.count), 0);
        cycle();
        checkOutput("t1_valid_drops", 32'(bus.valid_out), 0);
        checkOutput("t1_payload_zero", bus.rs1, 0);

        // src1 waits for tag 12, woken two cycles after dispatch.
        applyStimulus(1, 12, 0, 0, 0, 1, 3, 5, 10, 0);
        cycle();
        checkOutput("t2_waiting_count", 32'(bus.count), 1);
        checkOutput("t2_waiting_valid", 32'(bus.valid_out), 0);
        exp_q.push_back('{4'h1, 32'hAA, 32'd3, 6'd5, 6'd10, 1'b0});
        wakeup(12, 32'hAA);
        checkOutput("t2_no_issue_at_wakeup_edge", 32'(bus.valid_out), 0);
        cycle();
        checkOutput("t2_count_after_issue", 32'(bus.count), 0);
        cycle();

        // Same-cycle bypass of src2 from the writeback bus.
        bus.wb_valid = 1'b1; bus.wb_tag = 6'd4; bus.wb_value = 32'h11;
        exp_q.push_back('{4'h2, 32'h22, 32'h11, 6'd6, 6'd11, 1'b1});
        applyStimulus(2, 0, 1, 32'h22, 4, 0, 0, 6, 11, 1);
        bus.wb_valid = 1'b0;
        cycle();
        checkOutput("t3_count_after_issue", 32'(bus.count), 0);
        cycle();

        // Fill all 16 entries with waiting ops; a ready 17th is dropped.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(5, 20 + i, 0, 0, 0, 1, i, i, i, 0);
        end
        checkOutput("t4_full", 32'(bus.full), 1);
        checkOutput("t4_count_full", 32'(bus.count), 16);
        applyStimulus(6, 0, 1, 1, 0, 1, 1, 1, 1, 0);
        checkOutput("t4_count_after_drop", 32'(bus.count), 16);
        cycle();
        checkOutput("t4_no_issue_after_drop", 32'(bus.valid_out), 0);
        bus.flush = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_tag = 6'd20; bus.wb_value = 32'hF0;
        cycle();
        bus.flush = 1'b0;
        bus.wb_valid = 1'b0;
        checkOutput("t4_flush_count", 32'(bus.count), 0);
        checkOutput("t4_flush_full", 32'(bus.full), 0);
        checkOutput("t4_flush_valid", 32'(bus.valid_out), 0);
        wakeup(21, 1);
        cycle();
        checkOutput("t4_no_issue_after_flush", 32'(bus.valid_out), 0);

        // Entries 2 and 5 share tag 50 and wake together; entry 2 wins first.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i, (i == 2 || i == 5) ? 50 : 40 + i, 0, 0,
                          0, 1, i * 32'h100, 10 + i, 18 + i, 0);
        end
        checkOutput("t5_count", 32'(bus.count), 6);
        exp_q.push_back('{4'h2, 32'h55, 32'h200, 6'd12, 6'd20, 1'b0});
        exp_q.push_back('{4'h5, 32'h55, 32'h500, 6'd15, 6'd23, 1'b0});
        wakeup(50, 32'h55);
        cycle();
        checkOutput("t5_count_after_first", 32'(bus.count), 5);
        cycle();
        checkOutput("t5_count_after_second", 32'(bus.count), 4);
        cycle();
        checkOutput("t5_idle_after_pair", 32'(bus.valid_out), 0);

        // Refill freed slots to 6 busy, then reset asynchronously mid-cycle.
        applyStimulus(8, 60, 0, 0, 0, 1, 0, 1, 1, 0);
        applyStimulus(8, 61, 0, 0, 0, 1, 0, 1, 1, 0);
        checkOutput("t6_count_before_reset", 32'(bus.count), 6);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_count", 32'(bus.count), 0);
        checkOutput("t6_async_valid", 32'(bus.valid_out), 0);
        checkOutput("t6_async_full", 32'(bus.full), 0);
        cycle();
        rst = 1'b1;
        exp_q.push_back('{4'h7, 32'd1, 32'd2, 6'd8, 6'd30, 1'b0});
        applyStimulus(7, 0, 1, 1, 0, 1, 2, 8, 30, 0);
        cycle();
        checkOutput("t6_count_after_issue", 32'(bus.count), 0);
        wakeup(41, 32'h77);
        wakeup(60, 32'h78);
        cycle();
        checkOutput("t6_stale_entries_gone", 32'(bus.valid_out), 0);
        checkOutput("t6_final_count", 32'(bus.count), 0);

        cycle();
        cycle();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
